// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - control/target bus between datapath controller and pc_gen
//
// Carries the per-cycle control decisions (stall, exception, jal/jr/branch
// selects, branch offset, jal index, jr register value) into pc_gen and the
// PC, next-PC, return-address-stack prediction and mispredict count back out.
// master: controller/datapath side. slave: pc_gen.
interface pc_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              exc_req;
    logic              is_jal;
    logic              is_jr;
    logic              is_branch;
    logic              branch_taken;
    logic [15:0]       imm;
    logic [25:0]       ins_index;
    logic [ADDR_W-1:0] rs;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] ras_pred;
    logic              ras_valid;
    logic              jr_mispredict;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output stall, exc_req, is_jal, is_jr, is_branch, branch_taken,
               imm, ins_index, rs,
        input  pc, pc4, npc, ras_pred, ras_valid, jr_mispredict, mispredict_cnt
    );

    modport slave (
        input  stall, exc_req, is_jal, is_jr, is_branch, branch_taken,
               imm, ins_index, rs,
        output pc, pc4, npc, ras_pred, ras_valid, jr_mispredict, mispredict_cnt
    );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - MIPS program-counter generator with return-address stack
//
// Holds the architectural PC and selects the next PC (exception vector, jal,
// taken branch, jr, sequential). A circular return-address stack is pushed on
// jal and popped on jr; it only predicts jr targets and a saturating counter
// tallies jr mispredicts. The jr target itself always comes from rs.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - pc_gen_if.slave: control inputs in, pc/pc4/npc/RAS/counter out
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_4180),
    parameter int                RAS_DEPTH = 4,
    parameter int                CNT_W     = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.slave  bus
);
    localparam int TP_W  = $clog2(RAS_DEPTH);
    localparam int OCC_W = $clog2(RAS_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [TP_W-1:0]   tp_q, tp_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jal_tgt;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] ras_top;
    logic              br_sel;
    logic              jal_sel;
    logic              jr_sel;
    logic              ras_valid;
    logic              mispredict;
    logic              push;
    logic              pop;

    assign pc4     = pc_q + ADDR_W'(4);
    // imm counts words: shift by two, then sign-extend to the PC width.
    assign br_off  = {{(ADDR_W-18){bus.imm[15]}}, bus.imm, 2'b00};
    assign br_tgt  = pc4 + br_off;
    assign jal_tgt = {pc_q[ADDR_W-1:28], bus.ins_index, 2'b00};

    assign br_sel  = bus.is_branch & bus.branch_taken;
    assign jal_sel = bus.is_jal & ~bus.exc_req;
    assign jr_sel  = bus.is_jr & ~bus.exc_req & ~bus.is_jal & ~br_sel;

    always_comb begin
        npc = pc4;
        if (bus.exc_req) begin
            npc = EXC_VEC;
        end else if (bus.is_jal) begin
            npc = jal_tgt;
        end else if (br_sel) begin
            npc = br_tgt;
        end else if (bus.is_jr) begin
            npc = bus.rs;
        end
    end

    // Entries left behind by pops are stale, so the top is only meaningful
    // while the stack is occupied.
    assign ras_valid  = (occ_q != '0);
    assign ras_top    = ras_q[tp_q];
    assign mispredict = jr_sel & (~ras_valid | (ras_top != bus.rs));

    assign push = jal_sel & ~bus.stall;
    assign pop  = jr_sel & ~bus.stall & ras_valid;

    always_comb begin
        pc_d  = bus.stall ? pc_q : npc;
        tp_d  = tp_q;
        occ_d = occ_q;
        cnt_d = cnt_q;
        if (push) begin
            // tp wraps, so a push onto a full stack overwrites the oldest entry.
            tp_d = tp_q + TP_W'(1);
            if (occ_q != OCC_MAX) begin
                occ_d = occ_q + OCC_W'(1);
            end
        end else if (pop) begin
            tp_d  = tp_q - TP_W'(1);
            occ_d = occ_q - OCC_W'(1);
        end
        if (mispredict && !bus.stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            tp_q  <= '0;
            occ_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            tp_q  <= tp_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push) begin
                ras_q[tp_d] <= pc4;
            end
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc4            = pc4;
    assign bus.npc            = npc;
    assign bus.ras_pred       = ras_valid ? ras_top : '0;
    assign bus.ras_valid      = ras_valid;
    assign bus.jr_mispredict  = mispredict;
    assign bus.mispredict_cnt = cnt_q;
endmodule
